// File: rtl/piezo_pkg.sv
// Shared definitions for the piezo tone decoder and the piezo driver:
// note/pattern/state encodings, nominal tone periods, simulation scaling
// and the period/pattern classifiers.
package piezo_pkg;

  typedef enum logic [2:0] {
    NOTE_NONE = 3'd0,
    NOTE_G6   = 3'd1,
    NOTE_C7   = 3'd2,
    NOTE_E7   = 3'd3,
    NOTE_G7   = 3'd4,
    NOTE_UNK  = 3'd7
  } note_e;

  typedef enum logic [1:0] {
    PAT_NONE     = 2'd0,
    PAT_STEER    = 2'd1,
    PAT_TOO_FAST = 2'd2,
    PAT_BATT_LOW = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_TONE = 2'd2
  } state_e;

  // Nominal tone periods in 50 MHz clocks.
  localparam int unsigned NOM_G6 = 31888;
  localparam int unsigned NOM_C7 = 23889;
  localparam int unsigned NOM_E7 = 18961;
  localparam int unsigned NOM_G7 = 15944;

  // Fast simulation divides every period and timeout by 64.
  localparam int unsigned FAST_SHIFT   = 6;
  localparam int unsigned SILENCE_CLKS = 65536;

  localparam int unsigned DUR_W   = 26;
  localparam int unsigned SEQ_LEN = 6;
  localparam int unsigned SEQ_W   = 3 * SEQ_LEN;

  // Sequences are packed oldest note in the most significant slot.
  localparam logic [SEQ_W-1:0] SEQ_STEER =
    {NOTE_G6, NOTE_C7, NOTE_E7, NOTE_G7, NOTE_E7, NOTE_G7};
  localparam logic [SEQ_W-1:0] SEQ_BATT_LOW =
    {NOTE_G7, NOTE_E7, NOTE_G7, NOTE_E7, NOTE_C7, NOTE_G6};
  localparam logic [8:0] SEQ_TOO_FAST = {NOTE_G6, NOTE_C7, NOTE_E7};

  // Apply the simulation scaling to a clock count.
  function automatic int unsigned scaled(input int unsigned clocks, input bit fast);
    return fast ? (clocks >> FAST_SHIFT) : clocks;
  endfunction

  // True when p lies within +/- nom/16 of the nominal period.
  function automatic bit in_band(input logic [15:0] p, input int unsigned nom);
    int unsigned tol;
    tol = nom >> 4;
    return (32'(p) >= nom - tol) && (32'(p) <= nom + tol);
  endfunction

  // Map a measured period onto a note; anything outside every band is UNK.
  function automatic note_e classify_period(input logic [15:0] p, input bit fast);
    note_e n;
    n = NOTE_UNK;
    if (in_band(p, scaled(NOM_G6, fast)))      n = NOTE_G6;
    else if (in_band(p, scaled(NOM_C7, fast))) n = NOTE_C7;
    else if (in_band(p, scaled(NOM_E7, fast))) n = NOTE_E7;
    else if (in_band(p, scaled(NOM_G7, fast))) n = NOTE_G7;
    return n;
  endfunction

  // Classify the stored note sequence; cnt is the number of valid slots.
  function automatic pattern_e classify_pattern(input logic [SEQ_W-1:0] seq,
                                                input logic [2:0] cnt);
    pattern_e pat;
    pat = PAT_NONE;
    if (cnt == 3'd6 && seq == SEQ_STEER)              pat = PAT_STEER;
    else if (cnt == 3'd6 && seq == SEQ_BATT_LOW)      pat = PAT_BATT_LOW;
    else if (cnt == 3'd3 && seq[8:0] == SEQ_TOO_FAST) pat = PAT_TOO_FAST;
    return pat;
  endfunction

endpackage

// File: rtl/piezo_decode_if.sv
// Signal bundle between a piezo source/observer (master) and the decoder (slave).
interface piezo_decode_if;
  import piezo_pkg::*;

  logic             piezo;
  logic             piezo_n;
  note_e            note;
  logic             note_vld;
  logic [DUR_W-1:0] note_dur;
  logic             dur_vld;
  pattern_e         pattern;
  logic             pat_vld;
  logic             diff_err;

  modport master (
    output piezo, piezo_n,
    input  note, note_vld, note_dur, dur_vld, pattern, pat_vld, diff_err
  );

  modport slave (
    input  piezo, piezo_n,
    output note, note_vld, note_dur, dur_vld, pattern, pat_vld, diff_err
  );

endinterface

// File: rtl/piezo_prd_meas.sv
// Front end of the piezo decoder: input synchronizers, rising-edge detect,
// saturating period counter with classifier, silence timeout and the
// differential-pair integrity check.
module piezo_prd_meas
  import piezo_pkg::*;
#(
  parameter int FAST_SIM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        piezo,
  input  logic        piezo_n,
  output logic        p_vld,
  output logic [15:0] p,
  output note_e       p_note,
  output logic        silent,
  output logic        diff_err
);

  localparam bit          FAST         = (FAST_SIM != 0);
  localparam logic [15:0] SILENCE_LAST = 16'(scaled(SILENCE_CLKS, FAST) - 1);

  logic [1:0]  sync_p;
  logic [1:0]  sync_n;
  logic        prev_p;
  logic        rise;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic        timed_out;
  logic [1:0]  eq_cnt;

  // Two-flop synchronizers on both rails plus the edge-detect history flop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
      sync_n <= '0;
      prev_p <= 1'b0;
    end else begin
      sync_p <= {sync_p[0], piezo};
      sync_n <= {sync_n[0], piezo_n};
      prev_p <= sync_p[1];
    end
  end

  assign rise    = sync_p[1] & ~prev_p;
  // Count value one cycle on; it equals the clocks elapsed since the last edge.
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  // Period counter: clears on each edge, reporting and classifying the period.
  // A single silence pulse is raised once the gap reaches the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      timed_out <= 1'b0;
      p_vld     <= 1'b0;
      p         <= '0;
      p_note    <= NOTE_NONE;
      silent    <= 1'b0;
    end else begin
      p_vld  <= rise;
      silent <= 1'b0;
      if (rise) begin
        cnt       <= '0;
        timed_out <= 1'b0;
        p         <= cnt_inc;
        p_note    <= classify_period(cnt_inc, FAST);
      end else begin
        cnt <= cnt_inc;
        if (!timed_out && cnt == SILENCE_LAST) begin
          silent    <= 1'b1;
          timed_out <= 1'b1;
        end
      end
    end
  end

  // Sticky error once both rails read equal on four consecutive samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_cnt   <= '0;
      diff_err <= 1'b0;
    end else if (sync_p[1] == sync_n[1]) begin
      if (eq_cnt == 2'd3) diff_err <= 1'b1;
      else                eq_cnt   <= eq_cnt + 2'd1;
    end else begin
      eq_cnt <= '0;
    end
  end

endmodule

// File: rtl/piezo_decode.sv
// Piezo tone decoder: confirms notes from pairs of matching periods, reports
// note durations, and classifies the note sequence when the tone falls silent.
module piezo_decode
  import piezo_pkg::*;
#(
  parameter int FAST_SIM = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  piezo_decode_if.slave  bus
);

  localparam bit               FAST    = (FAST_SIM != 0);
  localparam int unsigned      SILENCE = scaled(SILENCE_CLKS, FAST);
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

  logic [1:0]       rst_sync;
  logic             rst_int_n;

  logic             p_vld;
  logic [15:0]      p;
  note_e            p_note;
  logic             silent;
  logic             diff_err;

  state_e           state;
  note_e            last_cls;
  logic             have_prev;
  logic [15:0]      p_prev;
  logic [DUR_W-1:0] dur;
  logic [SEQ_W-1:0] seq;
  logic [2:0]       seq_cnt;

  note_e            note;
  logic             note_vld;
  logic [DUR_W-1:0] note_dur;
  logic             dur_vld;
  pattern_e         pattern;
  logic             pat_vld;

  logic [16:0]      pair;
  logic [DUR_W:0]   end_dur;
  logic [DUR_W-1:0] change_dur;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  piezo_prd_meas #(
    .FAST_SIM (FAST_SIM)
  ) u_meas (
    .clk      (clk),
    .rst_n    (rst_int_n),
    .piezo    (bus.piezo),
    .piezo_n  (bus.piezo_n),
    .p_vld    (p_vld),
    .p        (p),
    .p_note   (p_note),
    .silent   (silent),
    .diff_err (diff_err)
  );

  // Length of the two periods that confirmed a note.
  assign pair = {1'b0, p_prev} + {1'b0, p};

  // At silence the timeout window is removed and the final cycle of the tone
  // is credited with the last measured period; overflow clamps to full scale.
  assign end_dur = {1'b0, dur} - (DUR_W+1)'(SILENCE) + {11'b0, p_prev};

  // On a note change the confirming pair already belongs to the new note.
  assign change_dur = (dur > {9'b0, pair}) ? dur - {9'b0, pair} : '0;

  // Decoder FSM with registered outputs; silence takes priority over any edge.
  // NOTE: the sequence register is reset with the rest of the state so a
  // reset mid-tone can never leak stale notes into the next pattern.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state     <= ST_IDLE;
      last_cls  <= NOTE_NONE;
      have_prev <= 1'b0;
      p_prev    <= '0;
      dur       <= '0;
      seq       <= '0;
      seq_cnt   <= '0;
      note      <= NOTE_NONE;
      note_vld  <= 1'b0;
      note_dur  <= '0;
      dur_vld   <= 1'b0;
      pattern   <= PAT_NONE;
      pat_vld   <= 1'b0;
    end else begin
      note_vld <= 1'b0;
      dur_vld  <= 1'b0;
      pat_vld  <= 1'b0;

      if (silent && state != ST_IDLE) begin
        if (state == ST_TONE) begin
          dur_vld  <= 1'b1;
          note_dur <= end_dur[DUR_W] ? DUR_MAX : end_dur[DUR_W-1:0];
        end
        pattern   <= classify_pattern(seq, seq_cnt);
        pat_vld   <= 1'b1;
        seq       <= '0;
        seq_cnt   <= '0;
        note      <= NOTE_NONE;
        have_prev <= 1'b0;
        dur       <= '0;
        state     <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            // First edge only starts the period counter.
            if (p_vld) begin
              have_prev <= 1'b0;
              state     <= ST_ACQ;
            end
          end

          ST_ACQ: begin
            if (p_vld) begin
              if (have_prev && p_note == last_cls) begin
                note     <= p_note;
                note_vld <= 1'b1;
                dur      <= DUR_W'(pair);
                seq      <= {seq[SEQ_W-4:0], p_note};
                seq_cnt  <= (seq_cnt == 3'(SEQ_LEN)) ? seq_cnt : seq_cnt + 3'd1;
                state    <= ST_TONE;
              end
              last_cls  <= p_note;
              p_prev    <= p;
              have_prev <= 1'b1;
            end
          end

          ST_TONE: begin
            dur <= (dur == DUR_MAX) ? dur : dur + 1'b1;
            if (p_vld) begin
              // A lone differing period is a glitch; two in a row are a new note.
              if (p_note != note && p_note == last_cls) begin
                note_dur <= change_dur;
                dur_vld  <= 1'b1;
                note     <= p_note;
                note_vld <= 1'b1;
                dur      <= DUR_W'(pair);
                seq      <= {seq[SEQ_W-4:0], p_note};
                seq_cnt  <= (seq_cnt == 3'(SEQ_LEN)) ? seq_cnt : seq_cnt + 3'd1;
              end
              last_cls <= p_note;
              p_prev   <= p;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.note     = note;
  assign bus.note_vld = note_vld;
  assign bus.note_dur = note_dur;
  assign bus.dur_vld  = dur_vld;
  assign bus.pattern  = pattern;
  assign bus.pat_vld  = pat_vld;
  assign bus.diff_err = diff_err;

endmodule
